serial_abs_sub: RTL

SERIAL_ABS_SUB -- requirements
Module: serial_abs_sub

---
 rtl/serial_abs_sub.sv | 130 +++++++++++++
 1 files changed

// File: rtl/serial_abs_sub.sv
// Bit-serial absolute difference |a - b| with a sign flag.
// The subtraction runs LSB first through a single 1-bit full subtractor.
// A final borrow means the raw result is negative, so a second serial pass
// computes 0 - result to recover the magnitude.
module serial_abs_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             neg
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SUB, NEG, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sa, sb, res, res_nxt;
    logic [CW-1:0]    cnt;
    logic             bw;
    logic             x, y, d, bout;
    logic             last_bit;

    // Returns {borrow_out, difference_bit} for x - y - bin.
    function automatic logic [1:0] full_sub(input logic xi, input logic yi, input logic bin);
        return {(~xi & yi) | (~(xi ^ yi) & bin), xi ^ yi ^ bin};
    endfunction

    assign last_bit     = (cnt == CW'(WIDTH - 1));
    assign {bout, d}    = full_sub(x, y, bw);
    // The result register doubles as the operand in NEG: bits leave at the
    // LSB while new bits enter at the MSB, so after WIDTH shifts it holds 0 - res.
    assign res_nxt      = {d, res[WIDTH-1:1]};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic, status outputs and subtractor operand selection.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        x         = 1'b0;
        y         = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = SUB;
            SUB: begin
                busy = 1'b1;
                x    = sa[0];
                y    = sb[0];
                if (last_bit) state_nxt = bout ? NEG : DONE;
            end
            NEG: begin
                busy = 1'b1;
                y    = res[0];
                if (last_bit) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Serial datapath; diff/neg are updated on entry to DONE so they are
    // valid during the done pulse and otherwise hold their previous values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sa   <= '0;
            sb   <= '0;
            res  <= '0;
            bw   <= 1'b0;
            cnt  <= '0;
            diff <= '0;
            neg  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sa  <= a;
                        sb  <= b;
                        res <= '0;
                        bw  <= 1'b0;
                        cnt <= '0;
                    end
                end
                SUB: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    res <= res_nxt;
                    if (last_bit) begin
                        bw  <= 1'b0;
                        cnt <= '0;
                        if (!bout) begin
                            diff <= res_nxt;
                            neg  <= 1'b0;
                        end
                    end else begin
                        bw  <= bout;
                        cnt <= cnt + CW'(1);
                    end
                end
                NEG: begin
                    res <= res_nxt;
                    if (last_bit) begin
                        bw   <= 1'b0;
                        cnt  <= '0;
                        diff <= res_nxt;
                        neg  <= 1'b1;
                    end else begin
                        bw  <= bout;
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
